// File: rtl/sram_mem_arbiter_if.sv
// Core-side SRAM request ports plus the shared req/ack memory bus seen by sram_mem_arbiter.
// master = the arbiter; slave = the core and memory it sits between.
interface sram_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          inst_en;
    logic [AW-1:0] inst_addr;
    logic          data_en;
    logic [3:0]    data_wen;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic [DW-1:0] inst_rdata;
    logic [DW-1:0] data_rdata;
    logic          stall_req;
    logic          mem_req;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    modport master (
        input  inst_en, inst_addr, data_en, data_wen, data_addr, data_wdata, mem_ack, mem_rdata,
        output inst_rdata, data_rdata, stall_req, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output inst_en, inst_addr, data_en, data_wen, data_addr, data_wdata, mem_ack, mem_rdata,
        input  inst_rdata, data_rdata, stall_req, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sram_mem_arbiter.sv
// Serialises core fetch and load/store onto one single-port req/ack memory bus, data first.
// Latency: 1 request cycle + (wait+1) per access + 1 DONE cycle; read data valid from DONE.
// Backpressure: stall_req freezes the core while an access is outstanding; mem_ack may take any time.
module sram_mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic               clk,
    input  logic               resetn,
    sram_mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, D_WAIT, I_WAIT, DONE} state_t;

    typedef struct packed {
        logic [3:0]    wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } dreq_t;

    state_t        state_q, state_d;
    dreq_t         dreq_q;
    logic [AW-1:0] iaddr_q;
    logic          inst_pend_q;
    logic [DW-1:0] inst_rdata_q;
    logic [DW-1:0] data_rdata_q;

    logic          stall_c;
    logic          mem_req_c;
    logic [3:0]    mem_we_c;
    logic [AW-1:0] mem_addr_c;
    logic [DW-1:0] mem_wdata_c;

    // Bus fields are driven only from capture registers so they cannot move while the core changes inputs.
    always_comb begin
        state_d     = state_q;
        stall_c     = 1'b0;
        mem_req_c   = 1'b0;
        mem_we_c    = 4'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        case (state_q)
            IDLE: begin
                stall_c = bus.inst_en | bus.data_en;
                if (bus.data_en) begin
                    state_d = D_WAIT;
                end else if (bus.inst_en) begin
                    state_d = I_WAIT;
                end
            end
            D_WAIT: begin
                stall_c     = 1'b1;
                mem_req_c   = 1'b1;
                mem_we_c    = dreq_q.wen;
                mem_addr_c  = dreq_q.addr;
                mem_wdata_c = dreq_q.wdata;
                if (bus.mem_ack) begin
                    state_d = inst_pend_q ? I_WAIT : DONE;
                end
            end
            I_WAIT: begin
                stall_c    = 1'b1;
                mem_req_c  = 1'b1;
                mem_addr_c = iaddr_q;
                if (bus.mem_ack) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            dreq_q       <= '0;
            iaddr_q      <= '0;
            inst_pend_q  <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.data_en) begin
                dreq_q      <= '{wen: bus.data_wen, addr: bus.data_addr, wdata: bus.data_wdata};
                iaddr_q     <= bus.inst_addr;
                inst_pend_q <= bus.inst_en;
            end else if (state_q == IDLE && bus.inst_en) begin
                iaddr_q     <= bus.inst_addr;
                inst_pend_q <= 1'b0;
            end
            // A store ack carries no useful data, so only loads update data_rdata.
            if (state_q == D_WAIT && bus.mem_ack && dreq_q.wen == 4'b0) begin
                data_rdata_q <= bus.mem_rdata;
            end
            if (state_q == I_WAIT && bus.mem_ack) begin
                inst_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.stall_req  = stall_c;
    assign bus.mem_req    = mem_req_c;
    assign bus.mem_we     = mem_we_c;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_wdata  = mem_wdata_c;
    assign bus.inst_rdata = inst_rdata_q;
    assign bus.data_rdata = data_rdata_q;
endmodule

// File: tb/tb_sram_mem_arbiter.sv
// Random core requests against a word-addressed memory model; bus accesses and read data scoreboarded.
module tb_sram_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    sram_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    sram_mem_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    typedef struct {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk_wdata;
    } acc_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] data;
    } resp_t;

    acc_t        bus_q[$];
    resp_t       resp_q[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] dev_mem[logic [31:0]];
    logic [31:0] exp_inst = 32'h0;
    logic [31:0] exp_data = 32'h0;
    int          checks = 0;
    int          errors = 0;
    int          fixed_wait = -1;
    bit          force_ack = 1'b0;
    int          sum_w1 = 0;
    int          obs_req = 0;

    function automatic void chk(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] dev_rd(input logic [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [3:0] we,
                                          input logic [31:0] d);
        logic [31:0] w = old_w;
        for (int b = 0; b < 4; b++) if (we[b]) w[b*8 +: 8] = d[b*8 +: 8];
        return w;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        ref_mem[a] = d;
        dev_mem[a] = d;
    endtask

    // Reference: data access happens before the fetch; read regs hold unless their access is a read.
    task automatic push_req(input bit ie, input logic [31:0] ia, input bit de,
                            input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd);
        acc_t  a;
        resp_t r;
        if (de) begin
            a.we = dw; a.addr = da; a.wdata = dd; a.chk_wdata = 1'b1;
            bus_q.push_back(a);
            if (dw == 4'b0) exp_data = ref_rd(da);
            else ref_mem[da] = merge(ref_rd(da), dw, dd);
        end
        if (ie) begin
            a.we = 4'b0; a.addr = ia; a.wdata = 32'h0; a.chk_wdata = 1'b0;
            bus_q.push_back(a);
            exp_inst = ref_rd(ia);
        end
        if (ie || de) begin
            r.inst = exp_inst;
            r.data = exp_data;
            resp_q.push_back(r);
        end
    endtask

    task automatic drive(input bit ie, input logic [31:0] ia, input bit de,
                         input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd);
        bus.inst_en = ie; bus.inst_addr = ia;
        bus.data_en = de; bus.data_wen = dw; bus.data_addr = da; bus.data_wdata = dd;
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the DONE cycle with requests dropped.
    task automatic issue(input bit ie, input logic [31:0] ia, input bit de,
                         input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd,
                         output int stall_cyc);
        int w0, r0;
        push_req(ie, ia, de, dw, da, dd);
        w0 = sum_w1;
        r0 = obs_req;
        drive(ie, ia, de, dw, da, dd);
        stall_cyc = 0;
        forever begin
            @(negedge clk);
            if (!bus.stall_req) break;
            stall_cyc++;
            if (stall_cyc > 200) begin
                checks++; errors++;
                $display("FAIL stall_timeout: actual=%0d cycles required<=200", stall_cyc);
                break;
            end
        end
        chk("req_cycles", obs_req - r0, sum_w1 - w0);
        chk("stall_len", stall_cyc, (ie || de) ? 1 + sum_w1 - w0 : 0);
        align();
        bus.inst_en = 1'b0;
        bus.data_en = 1'b0;
    endtask

    task automatic spur_ack();
        force_ack = 1'b1;
        @(negedge clk);
        chk("spur_stall0", bus.stall_req, 1'b0);
        #1 force_ack = 1'b0;
        @(negedge clk);
        chk("spur_stall1", bus.stall_req, 1'b0);
        chk("spur_req", bus.mem_req, 1'b0);
        chk("spur_inst", bus.inst_rdata, exp_inst);
        chk("spur_data", bus.data_rdata, exp_data);
        align();
    endtask

    // Memory responder and bus monitor.
    initial begin : responder
        bit          in_acc;
        int          wait_left;
        acc_t        cur;
        acc_t        ea;
        in_acc = 1'b0;
        wait_left = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                in_acc = 1'b0;
                bus.mem_ack = 1'b0;
            end else begin
                if (bus.mem_ack) begin
                    bus.mem_ack = 1'b0;
                    in_acc = 1'b0;
                end
                if (bus.mem_req) begin
                    obs_req++;
                    if (!in_acc) begin
                        if (bus_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL bus_unexpected: actual addr=%0h required=no access", bus.mem_addr);
                        end else begin
                            ea = bus_q.pop_front();
                            chk("bus_we", bus.mem_we, ea.we);
                            chk("bus_addr", bus.mem_addr, ea.addr);
                            if (ea.chk_wdata) chk("bus_wdata", bus.mem_wdata, ea.wdata);
                        end
                        cur.we = bus.mem_we; cur.addr = bus.mem_addr; cur.wdata = bus.mem_wdata;
                        wait_left = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3);
                        sum_w1 += wait_left + 1;
                        in_acc = 1'b1;
                    end else begin
                        chk("bus_hold", {bus.mem_we, bus.mem_addr, bus.mem_wdata},
                            {cur.we, cur.addr, cur.wdata});
                    end
                    if (wait_left == 0) begin
                        bus.mem_ack = 1'b1;
                        if (cur.we == 4'b0) begin
                            bus.mem_rdata = dev_rd(cur.addr);
                        end else begin
                            dev_mem[cur.addr] = merge(dev_rd(cur.addr), cur.we, cur.wdata);
                            bus.mem_rdata = $urandom;
                        end
                    end else begin
                        wait_left--;
                    end
                end else begin
                    chk("idle_we", bus.mem_we, 4'b0);
                    if (force_ack) begin
                        bus.mem_ack = 1'b1;
                        bus.mem_rdata = $urandom;
                    end
                end
            end
        end
    end

    // Completion monitor: a stall that drops marks the DONE cycle of a request.
    initial begin : monitor
        bit    prev;
        resp_t r;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev = 1'b0;
            end else begin
                if (prev && !bus.stall_req) begin
                    if (resp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL resp_unexpected: actual=completion required=none pending");
                    end else begin
                        r = resp_q.pop_front();
                        chk("inst_rdata", bus.inst_rdata, r.inst);
                        chk("data_rdata", bus.data_rdata, r.data);
                    end
                end
                prev = bus.stall_req;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int          st;
        bit          ie, de;
        logic [3:0]  dw;
        logic [31:0] ia, da;
        resetn = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_req", bus.mem_req, 1'b0);
        chk("rst_we", bus.mem_we, 4'h0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
        chk("rst_inst", bus.inst_rdata, 32'h0);
        chk("rst_data", bus.data_rdata, 32'h0);
        chk("rst_stall0", bus.stall_req, 1'b0);
        #1 bus.inst_en = 1'b1;
        #1 chk("rst_stall1", bus.stall_req, 1'b1);
        bus.inst_en = 1'b0;
        align();
        resetn = 1'b1;
        align();

        preload(32'hBFC00000, 32'h3C010001);
        preload(32'h80001000, 32'h12345678);
        preload(32'hBFC00004, 32'h24020005);

        fixed_wait = 0;
        issue(1'b1, 32'hBFC00000, 1'b0, 4'h0, 32'h0, 32'h0, st);
        chk("fetch_stall", st, 2);
        issue(1'b1, 32'hBFC00004, 1'b1, 4'h0, 32'h80001000, 32'h0, st);
        chk("ldfetch_stall", st, 3);
        fixed_wait = 3;
        issue(1'b0, 32'h0, 1'b1, 4'h3, 32'h80002000, 32'hAABBCCDD, st);
        chk("store_stall", st, 5);
        fixed_wait = 0;
        issue(1'b0, 32'h0, 1'b1, 4'h0, 32'h80002000, 32'h0, st);
        spur_ack();

        for (int k = 0; k < 3; k++) begin
            issue(1'b1, 32'(k * 4), 1'b0, 4'h0, 32'h0, 32'h0, st);
            chk("b2b_stall", st, 2);
        end

        // Reset in the middle of a slow load with a fetch queued behind it.
        fixed_wait = 6;
        push_req(1'b1, 32'hBFC00008, 1'b1, 4'h0, 32'h80001000, 32'h0);
        drive(1'b1, 32'hBFC00008, 1'b1, 4'h0, 32'h80001000, 32'h0);
        repeat (3) @(negedge clk);
        chk("pre_rst_req", bus.mem_req, 1'b1);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_req", bus.mem_req, 1'b0);
        chk("mid_rst_we", bus.mem_we, 4'h0);
        chk("mid_rst_addr", bus.mem_addr, 32'h0);
        chk("mid_rst_wdata", bus.mem_wdata, 32'h0);
        chk("mid_rst_inst", bus.inst_rdata, 32'h0);
        chk("mid_rst_data", bus.data_rdata, 32'h0);
        chk("mid_rst_stall", bus.stall_req, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        bus_q.delete();
        resp_q.delete();
        exp_inst = 32'h0;
        exp_data = 32'h0;
        @(negedge clk);
        align();
        resetn = 1'b1;
        spur_ack();
        fixed_wait = -1;
        issue(1'b1, 32'hBFC00000, 1'b0, 4'h0, 32'h0, 32'h0, st);

        for (int i = 0; i < 300 && errors < 20; i++) begin
            ie = 1'($urandom_range(0, 1));
            de = 1'($urandom_range(0, 1));
            dw = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            da = 32'h80000000 + 32'($urandom_range(0, 15) * 4);
            ia = ($urandom_range(0, 1) == 0) ? 32'h80000000 + 32'($urandom_range(0, 15) * 4)
                                             : 32'hBFC00000 + 32'($urandom_range(0, 15) * 4);
            issue(ie, ia, de, dw, da, $urandom, st);
            if (i % 37 == 5) spur_ack();
        end

        repeat (4) @(negedge clk);
        chk("resp_drained", resp_q.size(), 0);
        chk("bus_drained", bus_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
